// File: rtl/spi_master_param.sv
// spi_master_param: single-word SPI master, all four CPOL/CPHA modes, MSB first.
//   clk, m_rst     : system clock (rising edge), asynchronous active-low reset
//   start          : transfer request, accepted while busy is low
//   cpol, cpha     : SPI mode, latched at accept
//   slave_sel      : target slave index, latched at accept
//   tx_data        : word to send, latched at accept
//   miso           : serial data from slave
//   sclk, mosi     : serial clock and data to slave
//   ss_n           : active-low slave selects
//   rx_data        : last received word
//   busy, done     : transfer in progress / one-cycle completion pulse
//   sel_err        : valid with done when the latched slave_sel is out of range
module spi_master_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SS  = 4,
    parameter int unsigned CLK_DIV = 2,
    localparam int unsigned SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              m_rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SEL_W-1:0]  slave_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sel_err
);

    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0]  DIV_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_PEN   = EDGE_W'(2 * DATA_W - 1);
    localparam logic [NUM_SS-1:0] ONE_SS     = NUM_SS'(1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sel_err_q, sel_err_d;

    logic                div_last_c;
    logic                lead_c;
    logic                sel_ok_c;

    // State and output registers
    always_ff @(posedge clk or negedge m_rst) begin
        if (!m_rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sel_q     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= '1;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sel_q     <= sel_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sel_d      = sel_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sel_err_d  = 1'b0;
        div_last_c = (div_q == '0);
        // edge_q counts edges already made; the next one is leading when that count is even
        lead_c     = ~edge_q[0];
        sel_ok_c   = (32'(sel_q) < NUM_SS);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SETUP;
                    div_d   = DIV_RELOAD;
                    edge_d  = '0;
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sel_d   = slave_sel;
                    sclk_d  = cpol;
                    mosi_d  = tx_data[DATA_W-1];
                    // an out-of-range index shifts the bit out entirely, leaving all selects high
                    ss_n_d  = ~(ONE_SS << slave_sel);
                    busy_d  = 1'b1;
                end
            end

            SETUP: begin
                if (div_last_c) begin
                    // first (leading) edge; in CPHA=1 the MSB is already on mosi, so no advance
                    state_d = SHIFT;
                    div_d   = DIV_RELOAD;
                    edge_d  = EDGE_W'(1);
                    sclk_d  = ~cpol_q;
                    if (!cpha_q) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    end
                end else begin
                    div_d = div_q - CNT_W'(1);
                end
            end

            SHIFT: begin
                if (div_last_c) begin
                    div_d = DIV_RELOAD;
                    if (edge_q == EDGE_LAST) begin
                        state_d = HOLD;
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                        sclk_d = lead_c ? ~cpol_q : cpol_q;
                        if (lead_c != cpha_q) begin
                            // sampling edge: leading for CPHA=0, trailing for CPHA=1
                            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                        end else if (cpha_q || edge_q != EDGE_PEN) begin
                            // launch edge; CPHA=0 skips the final trailing edge
                            tx_sh_d = tx_sh_q << 1;
                            mosi_d  = tx_sh_q[DATA_W-2];
                        end
                    end
                end else begin
                    div_d = div_q - CNT_W'(1);
                end
            end

            HOLD: begin
                if (div_last_c) begin
                    state_d   = DONE;
                    ss_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    sel_err_d = ~sel_ok_c;
                end else begin
                    div_d = div_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: three instances (8b/4 selects/div 2,
// 8b/3 selects, 16b/div 1 loopback). Stimulus pushes expected completions;
// one monitor pops and compares at every done pulse.
module tb_spi_master_param;

    typedef struct {
        string       nm;
        logic [31:0] rx;
        logic        serr;
        int          lat;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_a  = 0;
    int acc_b  = 0;
    int acc_c  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: defaults
    logic       rst_a, start_a, cpol_a, cpha_a, miso_a, sclk_a, mosi_a, busy_a, done_a, serr_a;
    logic [1:0] sel_a;
    logic [7:0] tx_a, rx_a;
    logic [3:0] ss_n_a;
    // instance B: three selects
    logic       rst_b, start_b, miso_b, sclk_b, mosi_b, busy_b, done_b, serr_b;
    logic [1:0] sel_b;
    logic [7:0] tx_b, rx_b;
    logic [2:0] ss_n_b;
    // instance C: 16-bit, divide by 1, loopback
    logic        rst_c, start_c, sclk_c, mosi_c, busy_c, done_c, serr_c;
    logic [1:0]  sel_c;
    logic [15:0] tx_c, rx_c;
    logic [3:0]  ss_n_c;

    spi_master_param u_a (
        .clk(clk), .m_rst(rst_a), .start(start_a), .cpol(cpol_a), .cpha(cpha_a),
        .slave_sel(sel_a), .tx_data(tx_a), .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a),
        .ss_n(ss_n_a), .rx_data(rx_a), .busy(busy_a), .done(done_a), .sel_err(serr_a)
    );

    spi_master_param #(.DATA_W(8), .NUM_SS(3), .CLK_DIV(2)) u_b (
        .clk(clk), .m_rst(rst_b), .start(start_b), .cpol(1'b0), .cpha(1'b0),
        .slave_sel(sel_b), .tx_data(tx_b), .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b),
        .ss_n(ss_n_b), .rx_data(rx_b), .busy(busy_b), .done(done_b), .sel_err(serr_b)
    );

    spi_master_param #(.DATA_W(16), .NUM_SS(4), .CLK_DIV(1)) u_c (
        .clk(clk), .m_rst(rst_c), .start(start_c), .cpol(1'b0), .cpha(1'b0),
        .slave_sel(sel_c), .tx_data(tx_c), .miso(mosi_c), .sclk(sclk_c), .mosi(mosi_c),
        .ss_n(ss_n_c), .rx_data(rx_c), .busy(busy_c), .done(done_c), .sel_err(serr_c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic score(input exp_t e, input logic [31:0] rx, input logic serr, input int lat);
        chk({e.nm, " rx_data"}, rx, e.rx);
        chk({e.nm, " sel_err"}, 32'(serr), 32'(e.serr));
        chk({e.nm, " done cycle"}, 32'(lat), 32'(e.lat));
    endtask

    // mode-aware slave model for instance A
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_pend = 1'b0, s_first = 1'b1;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    assign miso_a = s_tx[7];

    always @(sclk_a) begin
        if (rst_a) begin
            if (sclk_a != s_cpol) begin
                s_pend = 1'b1;
                if (!s_cpha) s_rx = {s_rx[6:0], mosi_a};
                else if (s_first) s_first = 1'b0;
                else s_tx = s_tx << 1;
            end else if (s_pend) begin
                s_pend = 1'b0;
                if (!s_cpha) s_tx = s_tx << 1;
                else s_rx = {s_rx[6:0], mosi_a};
            end
        end
    end

    // accept tracking on the edge that actually samples start
    always @(posedge clk) begin
        if (rst_a && start_a && !busy_a) acc_a = cyc;
        if (rst_b && start_b && !busy_b) acc_b = cyc;
        if (rst_c && start_c && !busy_c) acc_c = cyc;
    end

    // monitor: pop expectation on every done pulse
    always @(negedge clk) begin
        if (rst_a && done_a) begin
            if (q_a.size() == 0) chk("A unexpected done", 32'(done_a), 32'd0);
            else score(q_a.pop_front(), 32'(rx_a), serr_a, cyc - acc_a);
        end
        if (rst_b && done_b) begin
            if (q_b.size() == 0) chk("B unexpected done", 32'(done_b), 32'd0);
            else score(q_b.pop_front(), 32'(rx_b), serr_b, cyc - acc_b);
        end
        if (rst_c && done_c) begin
            if (q_c.size() == 0) chk("C unexpected done", 32'(done_c), 32'd0);
            else score(q_c.pop_front(), 32'(rx_c), serr_c, cyc - acc_c);
        end
    end

    task automatic load_slave(input logic pol, input logic pha, input logic [7:0] sw);
        s_cpol = pol; s_cpha = pha; s_tx = sw; s_rx = 8'h00; s_pend = 1'b0; s_first = 1'b1;
    endtask

    task automatic push_a(input string nm, input logic [7:0] sw);
        exp_t e;
        e.nm = nm; e.rx = 32'(sw); e.serr = 1'b0; e.lat = 37;
        q_a.push_back(e);
    endtask

    // one transfer on A; disturb toggles start and all latched inputs mid-transfer
    task automatic run_a(input string nm, input logic pol, input logic pha, input logic [1:0] sel,
                         input logic [7:0] tx, input logic [7:0] sw, input logic [3:0] ss_exp,
                         input bit disturb);
        bit got = 1'b0;
        bit ss_bad = 1'b0;
        load_slave(pol, pha, sw);
        push_a(nm, sw);
        @(negedge clk);
        cpol_a = pol; cpha_a = pha; sel_a = sel; tx_a = tx; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk({nm, " setup sclk"}, 32'(sclk_a), 32'(pol));
        chk({nm, " setup mosi"}, 32'(mosi_a), 32'(tx[7]));
        for (int n = 0; n < 200 && !got; n++) begin
            if (busy_a && ss_n_a !== ss_exp) ss_bad = 1'b1;
            if (disturb && n == 5) begin
                start_a = 1'b1; tx_a = ~tx; cpol_a = ~pol; cpha_a = ~pha; sel_a = sel + 2'd1;
            end
            if (disturb && n == 6) start_a = 1'b0;
            @(negedge clk);
            if (done_a) got = 1'b1;
        end
        chk({nm, " done seen"}, 32'(got), 32'd1);
        chk({nm, " ss_n while busy"}, 32'(ss_bad), 32'd0);
        chk({nm, " idle sclk"}, 32'(sclk_a), 32'(pol));
        chk({nm, " ss_n at done"}, 32'(ss_n_a), 32'hF);
        chk({nm, " slave saw mosi"}, 32'(s_rx), 32'(tx));
    endtask

    initial begin
        int gap;
        bit got;
        bit ss_bad;
        rst_a = 1'b0; start_a = 1'b0; cpol_a = 1'b0; cpha_a = 1'b0; sel_a = 2'd0; tx_a = 8'h00;
        rst_b = 1'b0; start_b = 1'b0; sel_b = 2'd0; tx_b = 8'h00; miso_b = 1'b1;
        rst_c = 1'b0; start_c = 1'b0; sel_c = 2'd0; tx_c = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset ss_n", 32'(ss_n_a), 32'hF);
        chk("reset sclk", 32'(sclk_a), 32'd0);
        chk("reset mosi", 32'(mosi_a), 32'd0);
        chk("reset rx_data", 32'(rx_a), 32'd0);
        chk("reset busy/done/sel_err", {29'd0, busy_a, done_a, serr_a}, 32'd0);
        chk("reset B ss_n", 32'(ss_n_b), 32'h7);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (2) @(negedge clk);

        // basic mode 0 transfer
        run_a("m0 A5", 1'b0, 1'b0, 2'd2, 8'hA5, 8'h3C, 4'b1011, 1'b0);
        repeat (5) @(negedge clk);
        chk("rx_data holds", 32'(rx_a), 32'h3C);

        // all four modes, tx 0x81
        run_a("mode0", 1'b0, 1'b0, 2'd0, 8'h81, 8'h96, 4'b1110, 1'b0);
        run_a("mode1", 1'b0, 1'b1, 2'd1, 8'h81, 8'h69, 4'b1101, 1'b0);
        run_a("mode2", 1'b1, 1'b0, 2'd3, 8'h81, 8'hE1, 4'b0111, 1'b0);
        run_a("mode3", 1'b1, 1'b1, 2'd2, 8'h81, 8'h1E, 4'b1011, 1'b0);

        // inputs changing and start pulsing while busy
        run_a("disturb", 1'b0, 1'b1, 2'd1, 8'h4D, 8'hB2, 4'b1101, 1'b1);
        repeat (45) @(negedge clk);
        chk("no queued transfer", 32'(busy_a), 32'd0);

        // back-to-back with start held high
        load_slave(1'b0, 1'b0, 8'h5A);
        push_a("b2b 12", 8'h5A);
        push_a("b2b 34", 8'hC3);
        @(negedge clk);
        cpol_a = 1'b0; cpha_a = 1'b0; sel_a = 2'd2; tx_a = 8'h12; start_a = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (done_a) got = 1'b1;
        end
        chk("b2b first done seen", 32'(got), 32'd1);
        chk("b2b first slave saw mosi", 32'(s_rx), 32'h12);
        load_slave(1'b0, 1'b0, 8'hC3);
        tx_a = 8'h34;
        gap = 0;
        while (ss_n_a == 4'hF && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("b2b ss_n high cycles", 32'(gap), 32'd1);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (done_a) got = 1'b1;
        end
        chk("b2b second done seen", 32'(got), 32'd1);
        chk("b2b second slave saw mosi", 32'(s_rx), 32'h34);

        // reset in the middle of a transfer
        load_slave(1'b0, 1'b0, 8'hAA);
        @(negedge clk);
        sel_a = 2'd1; tx_a = 8'h55; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("abort ss_n", 32'(ss_n_a), 32'hF);
        chk("abort sclk", 32'(sclk_a), 32'd0);
        chk("abort busy", 32'(busy_a), 32'd0);
        chk("abort rx_data", 32'(rx_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (45) @(negedge clk);
        run_a("after reset", 1'b0, 1'b0, 2'd1, 8'h96, 8'h3C, 4'b1101, 1'b0);

        // out-of-range select on a 3-select instance
        begin
            exp_t e;
            e.nm = "B sel 3"; e.rx = 32'hFF; e.serr = 1'b1; e.lat = 37;
            q_b.push_back(e);
        end
        @(negedge clk);
        sel_b = 2'd3; tx_b = 8'h0F; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        got = 1'b0; ss_bad = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            if (ss_n_b !== 3'b111) ss_bad = 1'b1;
            @(negedge clk);
            if (done_b) got = 1'b1;
        end
        chk("B done seen", 32'(got), 32'd1);
        chk("B ss_n stays high", 32'(ss_bad), 32'd0);

        // 16-bit loopback with divide by 1
        begin
            exp_t e;
            e.nm = "C BEEF"; e.rx = 32'hBEEF; e.serr = 1'b0; e.lat = 35;
            q_c.push_back(e);
        end
        @(negedge clk);
        sel_c = 2'd0; tx_c = 16'hBEEF; start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (done_c) got = 1'b1;
        end
        chk("C done seen", 32'(got), 32'd1);

        repeat (3) @(negedge clk);
        chk("A pending expectations", 32'(q_a.size()), 32'd0);
        chk("B pending expectations", 32'(q_b.size()), 32'd0);
        chk("C pending expectations", 32'(q_c.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving bits per transfer (range 4..32).
REQ-002 The block SHALL have parameter NUM_SS, default 4, giving the number of slave-select lines (range 1..16).
REQ-003 The block SHALL have parameter CLK_DIV, default 2, giving clk cycles per sclk half-period (range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port m_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: transfer request, sampled only while busy=0.
REQ-007 The block SHALL have ports cpol and cpha, input, 1 bit each: SPI mode, latched at accept.
REQ-008 The block SHALL have port slave_sel, input, clog2(NUM_SS) bits (min 1): target slave, latched at accept.
REQ-009 The block SHALL have port tx_data, input, DATA_W bits: word to send, latched at accept.
REQ-010 The block SHALL have port miso, input, 1 bit: serial data from slave.
REQ-011 The block SHALL have port sclk, output, 1 bit: serial clock.
REQ-012 The block SHALL have port mosi, output, 1 bit: serial data to slave, MSB first.
REQ-013 The block SHALL have port ss_n, output, NUM_SS bits: active-low selects, one-hot-low when active.
REQ-014 The block SHALL have port rx_data, output, DATA_W bits: last received word.
REQ-015 The block SHALL have port busy, output, 1 bit: high from accept until done.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 The block SHALL have port sel_err, output, 1 bit: high with done when latched slave_sel >= NUM_SS.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-019 IDLE SHALL move to SETUP when start=1; this is the accept cycle (cycle 0), in which tx_data, cpol, cpha and slave_sel are latched and busy rises from the next edge.
REQ-020 In SETUP (CLK_DIV cycles) ss_n[sel] SHALL be low, sclk SHALL equal cpol, and mosi SHALL equal tx_data[DATA_W-1].
REQ-021 SHIFT SHALL produce 2*DATA_W sclk edges, each separated by CLK_DIV clk cycles, with an internal half-period counter reloading at every edge.
REQ-022 With cpha=0, miso SHALL be sampled on the leading (odd-numbered) edges and mosi SHALL advance on the trailing edges, except the final trailing edge.
REQ-023 With cpha=1, mosi SHALL advance on the leading edges and miso SHALL be sampled on the trailing edges.
REQ-024 The leading edge SHALL take sclk from cpol to ~cpol; the trailing edge SHALL return it to cpol.
REQ-025 HOLD SHALL last CLK_DIV cycles with sclk=cpol and the select still asserted.
REQ-026 In DONE (1 cycle), ss_n SHALL be all-ones, done=1, busy=0, rx_data SHALL be updated with the assembled word (MSB received first), and the FSM SHALL return to IDLE.
REQ-027 done SHALL occur in cycle 1+CLK_DIV*(2*DATA_W+2) after the accept cycle.
REQ-028 start asserted during the DONE cycle SHALL be accepted, giving back-to-back transfers with ss_n high for at least 1 cycle between them.
REQ-029 start while busy=1 SHALL be ignored, with no queueing.
REQ-030 If slave_sel >= NUM_SS, the transfer SHALL run with full timing, no ss_n bit asserted, and sel_err=1 during the done pulse.
REQ-031 Changes to tx_data, cpol, cpha or slave_sel while busy SHALL have no effect on the current transfer.
REQ-032 rx_data SHALL hold its value between transfers.

Reset
REQ-033 m_rst=0 SHALL asynchronously force: state=IDLE, sclk=0, mosi=0, ss_n=all-ones, rx_data=0, busy=0, done=0, sel_err=0, and clear all counters and latches.
REQ-034 Reset asserted mid-transfer SHALL abort immediately with no done pulse; after release, the block SHALL accept a new start normally.

Verification
REQ-035 The bench SHALL cover: DATA_W=8, CLK_DIV=2, mode 0, sel=2, tx=0xA5, slave echoes 0x3C -> MOSI bits 10100101, ss_n=4'b1011 while busy, rx_data=0x3C, done at cycle 37.
REQ-036 The bench SHALL cover all four cpol/cpha modes with tx=0x81 against a mode-matched slave model -> idle level correct, sampling edge correct, rx_data as expected.
REQ-037 The bench SHALL cover start held high across two transfers (0x12, then 0x34) -> second accepted in the DONE cycle, ss_n high exactly 1 cycle between them, two done pulses.
REQ-038 The bench SHALL cover m_rst pulsed low at cycle 10 of a transfer -> ss_n=all-ones and sclk=0 immediately, no done, next transfer correct.
REQ-039 The bench SHALL cover NUM_SS=3 with slave_sel=3 -> ss_n=3'b111 throughout, done with sel_err=1 at the nominal cycle.
REQ-040 The bench SHALL cover DATA_W=16, CLK_DIV=1, tx=0xBEEF, loopback miso=mosi -> rx_data=0xBEEF, done at cycle 35.
